reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Parametrised reorder buffer for the out-of-order RISC-V core, sitting between issue, the execution units' writeback buses and the architectural register file. It allocates one entry per issued instruction and accepts results from WB_PORTS independent writeback channels. It provides bypassed operand lookup for renamed registers and retires at most one instruction per cycle in program order. On commit of a mispredicted branch it flushes all speculative state and redirects fetch.

## Interface
- REG_ADDR_WIDTH, 5, architectural register index width
- Q_WIDTH, 4, entry index width; DEPTH = 2**Q_WIDTH
- WB_PORTS, 2, number of writeback channels
- clk_in  in  1  clock; all state changes on rising edge
- rst_in  in  1  synchronous, active-high reset
- rdy_in  in  1  global enable; low freezes all state, forces has_commit and flush low
- issue_valid  in  1  allocate entry at ROB_tail this cycle
- issue_reg  in  REG_ADDR_WIDTH  destination register (0 = no writeback)
- issue_is_branch  in  1  entry is a control-flow instruction
- issue_pred_pc  in  32  predicted next PC
- ROB_tail  out  Q_WIDTH  index the next issue will receive
- full / empty  out  1  count == DEPTH / count == 0
- wb_valid  in  WB_PORTS  per-channel result strobe
- wb_pos  in  WB_PORTS*Q_WIDTH  target entry, channel i at [i*Q_WIDTH +: Q_WIDTH]
- wb_value  in  WB_PORTS*32  result value
- wb_real_pc  in  WB_PORTS*32  resolved next PC (branches only)
- rob_pos_r1, rob_pos_r2  in  Q_WIDTH  lookup indices
- V1, V2  out  32  lookup values
- V1_ready, V2_ready  out  1  lookup value valid
- has_commit  out  1  head retires at this edge
- Commit_Q  out  Q_WIDTH  index of retiring entry
- Commit_reg  out  REG_ADDR_WIDTH  destination of retiring entry
- Commit_V  out  32  value of retiring entry
- flush  out  1  retiring entry is a mispredicted branch
- redirect_pc  out  32  resolved PC when flush = 1, else 0

## Operation
- Per-entry state: valid, ready, reg, value, is_branch, pred_pc, real_pc. Pointers head, tail (Q_WIDTH bits, wrap modulo DEPTH), count (Q_WIDTH+1 bits).
- Issue: when issue_valid & rdy_in & !full & !flush, write the entry at tail with valid=1, ready=0 and increment tail. Issue while full is dropped; the issuer must check full.
- Writeback: for each channel with wb_valid, set ready=1, value and real_pc at wb_pos. If two channels hit the same entry, the lowest channel index wins. Writeback to an invalid entry is ignored.
- Lookup (combinational): Vx_ready=1 if the entry is ready, or if any wb channel targets rob_pos_rx this cycle (bypass, lowest channel wins). Vx is the corresponding value. When not ready, Vx=0.
- Commit: has_commit = rdy_in & valid[head] & ready[head]. Commit_* reflect head. At the edge, clear valid[head] and increment head.
- Mispredict: flush = has_commit & is_branch[head] & (real_pc[head] != pred_pc[head]). At that edge, the head commits normally. All entries are then invalidated, head=tail=0 and count=0. The same-cycle issue and all writebacks are discarded.
- count: +1 on accepted issue, −1 on commit, unchanged when both occur. A full buffer with a same-cycle commit still rejects issue.

## Timing
- Reset values: head=tail=count=0, all valid/ready=0. This gives ROB_tail=0, full=0, empty=1, has_commit=0, flush=0, redirect_pc=0, Commit_*=0, Vx_ready=0.
- Issue → earliest commit: writeback in the cycle after issue, commit in the cycle after writeback (an entry cannot commit in its writeback cycle).
- Lookup bypass is zero-latency. Registered state is visible one cycle later.
- Reset has priority over all other inputs, including mid-flush and mid-commit.
- Wrap-around: tail reaching DEPTH−1 then issuing sets tail=0. full is derived from count, not from pointer equality.

## Structure
- rob_pkg: DEPTH derivation, entry field widths, NO_REG constant (0).
- Sub-module rob_lookup_port: one index in, entry arrays and wb channels in, value/ready out. Instanced twice.

## Test plan
- Reset then 3 issues (reg 1,2,3) → ROB_tail=3, count=3, has_commit=0.
- Writeback entry 0 value 0x11 on ch0 → next cycle has_commit=1, Commit_Q=0, Commit_reg=1, Commit_V=0x11.
- Lookup of entry 2 while ch1 writes 0xAB to it → V1_ready=1, V1=0xAB in the same cycle. Ch0 and ch1 both write entry 2 → ch0 value retained.
- Fill DEPTH=16 entries → full=1, 17th issue dropped. Commit one plus issue same cycle → issue rejected, count=15. Tail wraps to 0 on the next issue.
- Branch at head with pred_pc=0x100, real_pc=0x200 → flush=1, redirect_pc=0x200. Next cycle empty=1, ROB_tail=0, and an issue made in the flush cycle is absent.
- rdy_in=0 with a ready head → has_commit=0 and no state change. Assert rst_in mid-stream → all reset values next cycle.

Source files
------------

// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer.
//   XLEN       : width of result values and PCs
//   NO_REG     : destination index meaning "no architectural writeback"
//   rob_depth(): number of entries for a given entry-index width
package rob_pkg;

  localparam int XLEN   = 32;
  localparam int NO_REG = 0;

  function automatic int rob_depth(input int q_width);
    return 1 << q_width;
  endfunction

endpackage

// File: rtl/rob_lookup_port.sv
// One operand lookup port of the reorder buffer. Returns the value held by
// entry pos_i, bypassing any writeback that targets the entry this cycle.
//   pos_i       : entry index to look up
//   ready_i     : per-entry ready flags
//   value_i     : per-entry result values
//   wb_valid_i  : per-channel writeback strobe
//   wb_pos_i    : per-channel target entry, channel i at [i*Q_WIDTH +: Q_WIDTH]
//   wb_value_i  : per-channel result value, channel i at [i*XLEN +: XLEN]
//   value_o     : looked-up value (0 when not ready)
//   ready_o     : looked-up value is valid
module rob_lookup_port
  import rob_pkg::*;
#(
  parameter int Q_WIDTH  = 4,
  parameter int WB_PORTS = 2,
  localparam int DEPTH   = rob_depth(Q_WIDTH)
) (
  input  logic [Q_WIDTH-1:0]          pos_i,
  input  logic                        ready_i [DEPTH],
  input  logic [XLEN-1:0]             value_i [DEPTH],
  input  logic [WB_PORTS-1:0]         wb_valid_i,
  input  logic [WB_PORTS*Q_WIDTH-1:0] wb_pos_i,
  input  logic [WB_PORTS*XLEN-1:0]    wb_value_i,
  output logic [XLEN-1:0]             value_o,
  output logic                        ready_o
);

  always_comb begin
    ready_o = ready_i[pos_i];
    value_o = ready_i[pos_i] ? value_i[pos_i] : '0;
    // Walk channels from highest to lowest so the lowest channel wins.
    for (int i = WB_PORTS - 1; i >= 0; i--) begin
      if (wb_valid_i[i] && (wb_pos_i[i*Q_WIDTH +: Q_WIDTH] == pos_i)) begin
        ready_o = 1'b1;
        value_o = wb_value_i[i*XLEN +: XLEN];
      end
    end
  end

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates one entry per issued instruction, collects
// results from WB_PORTS writeback channels, serves two bypassed operand
// lookups and retires one instruction per cycle in program order. A
// retiring mispredicted branch flushes all speculative state.
//   clk_in, rst_in, rdy_in          : clock, sync active-high reset, global enable
//   issue_*                         : allocation request at ROB_tail
//   ROB_tail, full, empty           : allocation status
//   wb_valid/wb_pos/wb_value/wb_real_pc : writeback channels
//   rob_pos_r1/r2, V1/V2, V1_ready/V2_ready : operand lookups
//   has_commit, Commit_Q/reg/V      : retirement of the head entry
//   flush, redirect_pc              : mispredict recovery
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int Q_WIDTH        = 4,
  parameter int WB_PORTS       = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        issue_valid,
  input  logic [REG_ADDR_WIDTH-1:0]   issue_reg,
  input  logic                        issue_is_branch,
  input  logic [31:0]                 issue_pred_pc,
  output logic [Q_WIDTH-1:0]          ROB_tail,
  output logic                        full,
  output logic                        empty,
  input  logic [WB_PORTS-1:0]         wb_valid,
  input  logic [WB_PORTS*Q_WIDTH-1:0] wb_pos,
  input  logic [WB_PORTS*32-1:0]      wb_value,
  input  logic [WB_PORTS*32-1:0]      wb_real_pc,
  input  logic [Q_WIDTH-1:0]          rob_pos_r1,
  input  logic [Q_WIDTH-1:0]          rob_pos_r2,
  output logic [31:0]                 V1,
  output logic [31:0]                 V2,
  output logic                        V1_ready,
  output logic                        V2_ready,
  output logic                        has_commit,
  output logic [Q_WIDTH-1:0]          Commit_Q,
  output logic [REG_ADDR_WIDTH-1:0]   Commit_reg,
  output logic [31:0]                 Commit_V,
  output logic                        flush,
  output logic [31:0]                 redirect_pc
);

  localparam int DEPTH = rob_depth(Q_WIDTH);
  localparam int CNT_W = Q_WIDTH + 1;

  // Control state (reset)
  logic                      valid_q [DEPTH];
  logic                      valid_d [DEPTH];
  logic                      ready_q [DEPTH];
  logic                      ready_d [DEPTH];
  logic [Q_WIDTH-1:0]        head_q, head_d;
  logic [Q_WIDTH-1:0]        tail_q, tail_d;
  logic [CNT_W-1:0]          count_q, count_d;

  // Entry payload (not reset; qualified by valid/ready)
  logic [REG_ADDR_WIDTH-1:0] dest_q    [DEPTH];
  logic [REG_ADDR_WIDTH-1:0] dest_d    [DEPTH];
  logic [XLEN-1:0]           value_q   [DEPTH];
  logic [XLEN-1:0]           value_d   [DEPTH];
  logic                      is_br_q   [DEPTH];
  logic                      is_br_d   [DEPTH];
  logic [XLEN-1:0]           pred_pc_q [DEPTH];
  logic [XLEN-1:0]           pred_pc_d [DEPTH];
  logic [XLEN-1:0]           real_pc_q [DEPTH];
  logic [XLEN-1:0]           real_pc_d [DEPTH];

  logic [Q_WIDTH-1:0]        wb_idx [WB_PORTS];
  logic                      issue_acc;

  for (genvar g = 0; g < WB_PORTS; g++) begin : g_wb_idx
    assign wb_idx[g] = wb_pos[g*Q_WIDTH +: Q_WIDTH];
  end

  assign full        = (count_q == CNT_W'(DEPTH));
  assign empty       = (count_q == '0);
  assign ROB_tail    = tail_q;

  assign has_commit  = rdy_in & valid_q[head_q] & ready_q[head_q];
  assign flush       = has_commit & is_br_q[head_q] &
                       (real_pc_q[head_q] != pred_pc_q[head_q]);
  assign redirect_pc = flush ? real_pc_q[head_q] : '0;
  assign Commit_Q    = head_q;
  // Gated so the commit bus reads zero whenever nothing retires.
  assign Commit_reg  = has_commit ? dest_q[head_q]  : REG_ADDR_WIDTH'(NO_REG);
  assign Commit_V    = has_commit ? value_q[head_q] : '0;

  // A full buffer rejects issue even if the head retires this cycle.
  assign issue_acc   = issue_valid & rdy_in & ~full & ~flush;

  always_comb begin
    valid_d   = valid_q;
    ready_d   = ready_q;
    dest_d    = dest_q;
    value_d   = value_q;
    is_br_d   = is_br_q;
    pred_pc_d = pred_pc_q;
    real_pc_d = real_pc_q;
    head_d    = head_q;
    tail_d    = tail_q;
    count_d   = count_q;

    if (rdy_in) begin
      // Highest channel first so the lowest channel's write lands last.
      for (int i = WB_PORTS - 1; i >= 0; i--) begin
        if (wb_valid[i] && valid_q[wb_idx[i]]) begin
          ready_d[wb_idx[i]]   = 1'b1;
          value_d[wb_idx[i]]   = wb_value[i*XLEN +: XLEN];
          real_pc_d[wb_idx[i]] = wb_real_pc[i*XLEN +: XLEN];
        end
      end

      if (has_commit) begin
        valid_d[head_q] = 1'b0;
        ready_d[head_q] = 1'b0;
        head_d          = head_q + Q_WIDTH'(1);
      end

      if (issue_acc) begin
        valid_d[tail_q]   = 1'b1;
        ready_d[tail_q]   = 1'b0;
        dest_d[tail_q]    = issue_reg;
        is_br_d[tail_q]   = issue_is_branch;
        pred_pc_d[tail_q] = issue_pred_pc;
        tail_d            = tail_q + Q_WIDTH'(1);
      end

      count_d = count_q + CNT_W'(issue_acc) - CNT_W'(has_commit);

      // Mispredict: everything younger than the retiring branch is dropped.
      if (flush) begin
        for (int j = 0; j < DEPTH; j++) begin
          valid_d[j] = 1'b0;
          ready_d[j] = 1'b0;
        end
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= '{default: 1'b0};
      ready_q <= '{default: 1'b0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      ready_q <= ready_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_in) begin
    dest_q    <= dest_d;
    value_q   <= value_d;
    is_br_q   <= is_br_d;
    pred_pc_q <= pred_pc_d;
    real_pc_q <= real_pc_d;
  end

  rob_lookup_port #(
    .Q_WIDTH  (Q_WIDTH),
    .WB_PORTS (WB_PORTS)
  ) u_lookup_r1 (
    .pos_i      (rob_pos_r1),
    .ready_i    (ready_q),
    .value_i    (value_q),
    .wb_valid_i (wb_valid),
    .wb_pos_i   (wb_pos),
    .wb_value_i (wb_value),
    .value_o    (V1),
    .ready_o    (V1_ready)
  );

  rob_lookup_port #(
    .Q_WIDTH  (Q_WIDTH),
    .WB_PORTS (WB_PORTS)
  ) u_lookup_r2 (
    .pos_i      (rob_pos_r2),
    .ready_i    (ready_q),
    .value_i    (value_q),
    .wb_valid_i (wb_valid),
    .wb_pos_i   (wb_pos),
    .wb_value_i (wb_value),
    .value_o    (V2),
    .ready_o    (V2_ready)
  );

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer (default parameters:
// 5-bit registers, 16 entries, 2 writeback channels).
module tb_reorder_buffer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        issue_valid;
  logic [4:0]  issue_reg;
  logic        issue_is_branch;
  logic [31:0] issue_pred_pc;
  logic [3:0]  ROB_tail;
  logic        full, empty;
  logic [1:0]  wb_valid;
  logic [7:0]  wb_pos;
  logic [63:0] wb_value;
  logic [63:0] wb_real_pc;
  logic [3:0]  rob_pos_r1, rob_pos_r2;
  logic [31:0] V1, V2;
  logic        V1_ready, V2_ready;
  logic        has_commit;
  logic [3:0]  Commit_Q;
  logic [4:0]  Commit_reg;
  logic [31:0] Commit_V;
  logic        flush;
  logic [31:0] redirect_pc;

  int nvec = 0;
  int nerr = 0;

  always #5 clk_in = ~clk_in;

  reorder_buffer dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_reg(issue_reg),
    .issue_is_branch(issue_is_branch), .issue_pred_pc(issue_pred_pc),
    .ROB_tail(ROB_tail), .full(full), .empty(empty),
    .wb_valid(wb_valid), .wb_pos(wb_pos), .wb_value(wb_value),
    .wb_real_pc(wb_real_pc),
    .rob_pos_r1(rob_pos_r1), .rob_pos_r2(rob_pos_r2),
    .V1(V1), .V2(V2), .V1_ready(V1_ready), .V2_ready(V2_ready),
    .has_commit(has_commit), .Commit_Q(Commit_Q), .Commit_reg(Commit_reg),
    .Commit_V(Commit_V), .flush(flush), .redirect_pc(redirect_pc)
  );

  // Inputs change 1 time unit after a rising edge; outputs are sampled
  // 1 more unit later, well away from the next edge.
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_reg = 0; issue_is_branch = 0; issue_pred_pc = 0;
    wb_valid = 0; wb_pos = 0; wb_value = 0; wb_real_pc = 0;
  endtask

  task automatic issue(input logic [4:0] r, input logic br, input logic [31:0] ppc);
    issue_valid = 1; issue_reg = r; issue_is_branch = br; issue_pred_pc = ppc;
  endtask

  task automatic wb(input int ch, input logic [3:0] pos, input logic [31:0] val,
                    input logic [31:0] rpc);
    wb_valid[ch] = 1'b1;
    wb_pos[ch*4 +: 4] = pos;
    wb_value[ch*32 +: 32] = val;
    wb_real_pc[ch*32 +: 32] = rpc;
  endtask

  task automatic do_reset();
    idle(); rst_in = 1; rdy_in = 1;
    tick(); tick();
    rst_in = 0; #1;
  endtask

  task automatic test_reset();
    logic [87:0] got, exp;
    do_reset();
    rob_pos_r1 = 0; rob_pos_r2 = 5; #1;
    got = {ROB_tail, full, empty, has_commit, flush, redirect_pc, Commit_Q,
           Commit_reg, Commit_V, V1_ready, V2_ready};
    exp = {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 5'd0, 32'd0, 1'b0, 1'b0};
    nvec++;
    if (got !== exp) begin
      nerr++; $display("FAIL reset_state got=%h exp=%h", got, exp);
    end
  endtask

  task automatic test_issue();
    for (int i = 1; i <= 3; i++) begin
      issue(5'(i), 0, 32'h0); tick();
    end
    idle(); #1;
    nvec++;
    if ({ROB_tail, empty, full, has_commit} !== {4'd3, 3'b000}) begin
      nerr++; $display("FAIL issue3 tail=%0d e=%b f=%b hc=%b exp tail=3 e=0 f=0 hc=0",
                       ROB_tail, empty, full, has_commit);
    end
  endtask

  task automatic test_writeback_commit();
    wb(0, 4'd0, 32'h11, 32'h0); #1;
    nvec++;
    if (has_commit !== 1'b0) begin
      nerr++; $display("FAIL commit_in_wb_cycle got=%b exp=0", has_commit);
    end
    tick(); idle(); #1;
    nvec++;
    if ({has_commit, Commit_Q, Commit_reg, Commit_V} !== {1'b1, 4'd0, 5'd1, 32'h11}) begin
      nerr++; $display("FAIL commit0 hc=%b q=%0d reg=%0d v=%h exp 1/0/1/11",
                       has_commit, Commit_Q, Commit_reg, Commit_V);
    end
    tick(); #1;
    nvec++;
    if ({has_commit, empty, Commit_Q} !== {1'b0, 1'b0, 4'd1}) begin
      nerr++; $display("FAIL after_commit0 hc=%b e=%b q=%0d exp 0/0/1",
                       has_commit, empty, Commit_Q);
    end
  endtask

  task automatic test_bypass();
    rob_pos_r1 = 4'd2; rob_pos_r2 = 4'd1;
    wb(1, 4'd2, 32'hAB, 32'h0); #1;
    nvec++;
    if ({V1_ready, V1, V2_ready, V2} !== {1'b1, 32'hAB, 1'b0, 32'h0}) begin
      nerr++; $display("FAIL bypass_ch1 V1r=%b V1=%h V2r=%b V2=%h exp 1/AB/0/0",
                       V1_ready, V1, V2_ready, V2);
    end
    tick(); idle();
    wb(0, 4'd2, 32'h22, 32'h0); wb(1, 4'd2, 32'h33, 32'h0); #1;
    nvec++;
    if ({V1_ready, V1} !== {1'b1, 32'h22}) begin
      nerr++; $display("FAIL bypass_prio V1r=%b V1=%h exp 1/22", V1_ready, V1);
    end
    tick(); idle(); #1;
    nvec++;
    if ({V1_ready, V1, has_commit} !== {1'b1, 32'h22, 1'b0}) begin
      nerr++; $display("FAIL wb_prio_reg V1r=%b V1=%h hc=%b exp 1/22/0",
                       V1_ready, V1, has_commit);
    end
    wb(0, 4'd1, 32'h44, 32'h0); tick(); idle(); #1;
    nvec++;
    if ({has_commit, Commit_Q, Commit_reg, Commit_V} !== {1'b1, 4'd1, 5'd2, 32'h44}) begin
      nerr++; $display("FAIL commit1 hc=%b q=%0d reg=%0d v=%h exp 1/1/2/44",
                       has_commit, Commit_Q, Commit_reg, Commit_V);
    end
    tick(); #1;
    nvec++;
    if ({has_commit, Commit_Q, Commit_reg, Commit_V} !== {1'b1, 4'd2, 5'd3, 32'h22}) begin
      nerr++; $display("FAIL commit2 hc=%b q=%0d reg=%0d v=%h exp 1/2/3/22",
                       has_commit, Commit_Q, Commit_reg, Commit_V);
    end
    tick(); #1;
    nvec++;
    if ({empty, ROB_tail, has_commit} !== {1'b1, 4'd3, 1'b0}) begin
      nerr++; $display("FAIL drained e=%b tail=%0d hc=%b exp 1/3/0", empty, ROB_tail, has_commit);
    end
    rob_pos_r1 = 0; rob_pos_r2 = 0;
  endtask

  task automatic test_full_wrap();
    do_reset();
    for (int i = 0; i < 15; i++) begin
      issue(5'(i + 1), 0, 32'h0); tick();
    end
    idle(); #1;
    nvec++;
    if ({ROB_tail, full} !== {4'd15, 1'b0}) begin
      nerr++; $display("FAIL fill15 tail=%0d full=%b exp 15/0", ROB_tail, full);
    end
    issue(5'd16, 0, 32'h0); tick(); idle(); #1;
    nvec++;
    if ({ROB_tail, full, empty} !== {4'd0, 1'b1, 1'b0}) begin
      nerr++; $display("FAIL fill16_wrap tail=%0d full=%b e=%b exp 0/1/0", ROB_tail, full, empty);
    end
    issue(5'd31, 0, 32'h0); tick(); idle(); #1;
    nvec++;
    if ({ROB_tail, full} !== {4'd0, 1'b1}) begin
      nerr++; $display("FAIL issue_when_full tail=%0d full=%b exp 0/1", ROB_tail, full);
    end
    wb(0, 4'd0, 32'h55, 32'h0); tick(); idle();
    issue(5'd30, 0, 32'h0); #1;
    nvec++;
    if ({has_commit, Commit_reg, Commit_V} !== {1'b1, 5'd1, 32'h55}) begin
      nerr++; $display("FAIL full_commit hc=%b reg=%0d v=%h exp 1/1/55",
                       has_commit, Commit_reg, Commit_V);
    end
    tick(); idle(); #1;
    nvec++;
    if ({ROB_tail, full} !== {4'd0, 1'b0}) begin
      nerr++; $display("FAIL full_commit_issue tail=%0d full=%b exp 0/0", ROB_tail, full);
    end
    issue(5'd29, 0, 32'h0); tick(); idle(); #1;
    nvec++;
    if ({ROB_tail, full} !== {4'd1, 1'b1}) begin
      nerr++; $display("FAIL refill tail=%0d full=%b exp 1/1", ROB_tail, full);
    end
  endtask

  task automatic test_flush();
    do_reset();
    issue(5'd5, 1, 32'h100); tick();
    issue(5'd6, 0, 32'h0);   tick(); idle();
    wb(0, 4'd0, 32'h77, 32'h200); wb(1, 4'd1, 32'h88, 32'h0); tick(); idle();
    issue(5'd7, 0, 32'h0); #1;
    nvec++;
    if ({has_commit, flush, redirect_pc, Commit_Q, Commit_reg, Commit_V} !==
        {1'b1, 1'b1, 32'h200, 4'd0, 5'd5, 32'h77}) begin
      nerr++; $display("FAIL mispredict hc=%b fl=%b pc=%h q=%0d reg=%0d v=%h exp 1/1/200/0/5/77",
                       has_commit, flush, redirect_pc, Commit_Q, Commit_reg, Commit_V);
    end
    tick(); idle(); rob_pos_r1 = 4'd1; #1;
    nvec++;
    if ({empty, ROB_tail, has_commit, flush, V1_ready} !== {1'b1, 4'd0, 3'b000}) begin
      nerr++; $display("FAIL post_flush e=%b tail=%0d hc=%b fl=%b V1r=%b exp 1/0/0/0/0",
                       empty, ROB_tail, has_commit, flush, V1_ready);
    end
    rob_pos_r1 = 0;
    issue(5'd8, 1, 32'h300); tick(); idle();
    wb(1, 4'd0, 32'h12, 32'h300); tick(); idle(); #1;
    nvec++;
    if ({has_commit, flush, redirect_pc, Commit_V} !== {1'b1, 1'b0, 32'h0, 32'h12}) begin
      nerr++; $display("FAIL good_branch hc=%b fl=%b pc=%h v=%h exp 1/0/0/12",
                       has_commit, flush, redirect_pc, Commit_V);
    end
    tick(); #1;
    nvec++;
    if ({empty, ROB_tail} !== {1'b1, 4'd1}) begin
      nerr++; $display("FAIL good_branch_retired e=%b tail=%0d exp 1/1", empty, ROB_tail);
    end
  endtask

  task automatic test_rdy();
    issue(5'd9, 0, 32'h0); tick(); idle();
    wb(0, 4'd1, 32'h99, 32'h0); tick(); idle();
    rdy_in = 0; issue(5'd10, 0, 32'h0); #1;
    nvec++;
    if ({has_commit, flush} !== 2'b00) begin
      nerr++; $display("FAIL rdy_low hc=%b fl=%b exp 0/0", has_commit, flush);
    end
    tick(); tick(); idle(); rdy_in = 1; #1;
    nvec++;
    if ({ROB_tail, has_commit, Commit_Q, Commit_V} !== {4'd2, 1'b1, 4'd1, 32'h99}) begin
      nerr++; $display("FAIL rdy_resume tail=%0d hc=%b q=%0d v=%h exp 2/1/1/99",
                       ROB_tail, has_commit, Commit_Q, Commit_V);
    end
    tick(); #1;
    nvec++;
    if (empty !== 1'b1) begin
      nerr++; $display("FAIL rdy_drain e=%b exp 1", empty);
    end
  endtask

  task automatic test_reset_mid();
    issue(5'd11, 1, 32'h400); tick(); idle();
    wb(0, 4'd2, 32'h1, 32'h500); tick(); idle(); #1;
    nvec++;
    if (flush !== 1'b1) begin
      nerr++; $display("FAIL pre_reset_flush got=%b exp 1", flush);
    end
    rst_in = 1; issue(5'd12, 0, 32'h0); wb(1, 4'd3, 32'h5, 32'h0);
    tick(); rst_in = 0; idle(); rob_pos_r1 = 4'd2; #1;
    nvec++;
    if ({ROB_tail, full, empty, has_commit, flush, redirect_pc, Commit_Q, Commit_reg,
         Commit_V, V1_ready} !==
        {4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 5'd0, 32'd0, 1'b0}) begin
      nerr++; $display("FAIL reset_mid tail=%0d f=%b e=%b hc=%b fl=%b pc=%h q=%0d reg=%0d v=%h V1r=%b exp all reset",
                       ROB_tail, full, empty, has_commit, flush, redirect_pc, Commit_Q,
                       Commit_reg, Commit_V, V1_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rob_pos_r1 = 0; rob_pos_r2 = 0;
    test_reset();
    test_issue();
    test_writeback_commit();
    test_bypass();
    test_full_wrap();
    test_flush();
    test_rdy();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
